// File: rtl/deserializer_unit_cell.sv
// Serial-to-parallel receiver: rebuilds eight 32-bit LSB-first words from a 1-bit stream
// and presents them on registered parallel outputs with per-word and per-frame strobes.
module deserializer_unit_cell #(
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SERIAL_IN,
  input  logic        SERIAL_VALID,
  input  logic        SYNC,
  output logic [31:0] PAR_OUT1,
  output logic [31:0] PAR_OUT2,
  output logic [31:0] PAR_OUT3,
  output logic [31:0] PAR_OUT4,
  output logic [31:0] PAR_OUT5,
  output logic [31:0] PAR_OUT6,
  output logic [31:0] PAR_OUT7,
  output logic [31:0] PAR_OUT8,
  output logic        WORD_VALID,
  output logic [2:0]  WORD_INDEX,
  output logic        FRAME_VALID,
  output logic        BUSY
);

  typedef enum logic {RECV = 1'b0, DONE = 1'b1} state_t;

  state_t       state_reg, state_next;
  logic [4:0]   bit_cnt_reg, bit_cnt_next;
  logic [2:0]   word_cnt_reg, word_cnt_next;
  logic [31:0]  word_buf_reg, word_buf_next;
  logic         word_valid_reg, word_valid_next;
  logic [2:0]   word_index_reg, word_index_next;
  logic         frame_valid_reg, frame_valid_next;
  logic         load_word;
  logic [31:0]  load_data;
  logic [7:0][31:0] par_reg;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg       <= RECV;
      bit_cnt_reg     <= '0;
      word_cnt_reg    <= '0;
      word_buf_reg    <= '0;
      word_valid_reg  <= 1'b0;
      word_index_reg  <= '0;
      frame_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      word_cnt_reg    <= word_cnt_next;
      word_buf_reg    <= word_buf_next;
      word_valid_reg  <= word_valid_next;
      word_index_reg  <= word_index_next;
      frame_valid_reg <= frame_valid_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    word_cnt_next    = word_cnt_reg;
    word_buf_next    = word_buf_reg;
    word_valid_next  = 1'b0;
    word_index_next  = word_index_reg;
    frame_valid_next = 1'b0;
    load_word        = 1'b0;
    load_data        = {SERIAL_IN, word_buf_reg[30:0]};
    // SYNC wins over any bit presented in the same cycle, including a word's last bit
    if (SYNC) begin
      state_next    = RECV;
      bit_cnt_next  = '0;
      word_cnt_next = '0;
      word_buf_next = '0;
    end else if (state_reg == RECV && SERIAL_VALID) begin
      if (bit_cnt_reg != 5'd31) begin
        word_buf_next[bit_cnt_reg] = SERIAL_IN;
        bit_cnt_next               = bit_cnt_reg + 5'd1;
      end else begin
        load_word       = 1'b1;
        word_valid_next = 1'b1;
        word_index_next = word_cnt_reg;
        bit_cnt_next    = '0;
        word_buf_next   = '0;
        if (word_cnt_reg == 3'd7) begin
          frame_valid_next = 1'b1;
          word_cnt_next    = '0;
          if (!CONTINUOUS) state_next = DONE;
        end else begin
          word_cnt_next = word_cnt_reg + 3'd1;
        end
      end
    end
  end

  // Each output word register only moves on its own completion edge
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_word
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
          par_reg[gi] <= '0;
        else if (load_word && word_cnt_reg == 3'(gi))
          par_reg[gi] <= load_data;
      end
    end
  endgenerate

  assign PAR_OUT1    = par_reg[0];
  assign PAR_OUT2    = par_reg[1];
  assign PAR_OUT3    = par_reg[2];
  assign PAR_OUT4    = par_reg[3];
  assign PAR_OUT5    = par_reg[4];
  assign PAR_OUT6    = par_reg[5];
  assign PAR_OUT7    = par_reg[6];
  assign PAR_OUT8    = par_reg[7];
  assign WORD_VALID  = word_valid_reg;
  assign WORD_INDEX  = word_index_reg;
  assign FRAME_VALID = frame_valid_reg;
  assign BUSY        = (state_reg == RECV) && (bit_cnt_reg != 5'd0 || word_cnt_reg != 3'd0);

endmodule
